// File: rtl/l2_refill_pkg.sv
// Shared types and constants for the L2 refill sequencer.
package l2_refill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BEAT
    } refill_state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

    localparam int L2_BEAT_BYTES = 8;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_IC) ? OWN_DC : OWN_IC;
    endfunction

endpackage

// File: rtl/refill_rr_arb2.sv
// Two-way round-robin pick between the icache and dcache refill permits.
module refill_rr_arb2
    import l2_refill_pkg::*;
(
    input  logic   ic_permit,
    input  logic   dc_permit,
    input  owner_t rr_ptr,
    output logic   grant_valid,
    output owner_t grant_owner
);

    // rr_ptr names the side that wins a tie; a lone requester always wins.
    always_comb begin
        grant_valid = ic_permit | dc_permit;
        grant_owner = OWN_IC;
        if (ic_permit && dc_permit) begin
            grant_owner = rr_ptr;
        end else if (dc_permit) begin
            grant_owner = OWN_DC;
        end
    end

endmodule

// File: rtl/l2_refill_arb.sv
// Grants one L1 miss at a time to the L2 refill port and forwards the
// returning beats to the owning cache as registered words with ready pulses.
module l2_refill_arb
    import l2_refill_pkg::*;
#(
    parameter int B = 64
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          ic_repl_permit_i,
    input  logic [31:0]   ic_addr_i,
    input  logic          dc_repl_permit_i,
    input  logic [31:0]   dc_addr_i,
    output logic          ic_repl_ready_o,
    output logic          dc_repl_ready_o,
    output logic          ic_done_o,
    output logic          dc_done_o,
    output logic [63:0]   rep_word_o,
    output logic          l2_req_o,
    output logic [31:0]   l2_addr_o,
    input  logic          l2_ack_i,
    input  logic          l2_rvalid_i,
    input  logic [63:0]   l2_rdata_i,
    output refill_state_t state_o
);

    localparam int BEATS = B / L2_BEAT_BYTES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [31:0]   LINE_MASK = ~(32'(B) - 32'd1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    refill_state_t state;
    owner_t        owner;
    owner_t        rr_ptr;
    logic [BW-1:0] beat_cnt;
    logic          grant_valid;
    owner_t        grant_owner;

    refill_rr_arb2 u_rr_arb (
        .ic_permit   (ic_repl_permit_i),
        .dc_permit   (dc_repl_permit_i),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // L2 handshake: l2_req_o is held with a stable l2_addr_o until the cycle
    // l2_ack_i is sampled high; each l2_rvalid_i sampled in BEAT is one beat,
    // and the owner's ready pulses for exactly one cycle on the following cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state           <= IDLE;
            owner           <= OWN_IC;
            rr_ptr          <= OWN_IC;
            beat_cnt        <= '0;
            ic_repl_ready_o <= 1'b0;
            dc_repl_ready_o <= 1'b0;
            ic_done_o       <= 1'b0;
            dc_done_o       <= 1'b0;
            rep_word_o      <= '0;
            l2_req_o        <= 1'b0;
            l2_addr_o       <= '0;
        end else begin
            ic_repl_ready_o <= 1'b0;
            dc_repl_ready_o <= 1'b0;
            ic_done_o       <= 1'b0;
            dc_done_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_owner;
                        l2_addr_o <= ((grant_owner == OWN_DC) ? dc_addr_i : ic_addr_i) & LINE_MASK;
                        beat_cnt  <= '0;
                        l2_req_o  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (l2_ack_i) begin
                        l2_req_o <= 1'b0;
                        state    <= BEAT;
                    end
                end
                BEAT: begin
                    if (l2_rvalid_i) begin
                        rep_word_o      <= l2_rdata_i;
                        ic_repl_ready_o <= (owner == OWN_IC);
                        dc_repl_ready_o <= (owner == OWN_DC);
                        if (beat_cnt == LAST_BEAT) begin
                            ic_done_o <= (owner == OWN_IC);
                            dc_done_o <= (owner == OWN_DC);
                            rr_ptr    <= other_owner(owner);
                            state     <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_l2_refill_arb.sv
// Directed bench for l2_refill_arb at B=64 and B=32 with hand-computed expectations.
module tb_l2_refill_arb;
    import l2_refill_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic        ic_permit, dc_permit;
    logic [31:0] ic_addr, dc_addr;
    logic        l2_ack, l2_rvalid;
    logic [63:0] l2_rdata;

    logic a_ic_rdy, a_dc_rdy, a_ic_done, a_dc_done, a_req;
    logic b_ic_rdy, b_dc_rdy, b_ic_done, b_dc_done, b_req;
    logic [63:0] a_word, b_word;
    logic [31:0] a_addr, b_addr;
    refill_state_t a_state, b_state;

    l2_refill_arb #(.B(64)) dut64 (
        .clk_i(clk), .reset_i(reset_i),
        .ic_repl_permit_i(ic_permit), .ic_addr_i(ic_addr),
        .dc_repl_permit_i(dc_permit), .dc_addr_i(dc_addr),
        .ic_repl_ready_o(a_ic_rdy), .dc_repl_ready_o(a_dc_rdy),
        .ic_done_o(a_ic_done), .dc_done_o(a_dc_done),
        .rep_word_o(a_word), .l2_req_o(a_req), .l2_addr_o(a_addr),
        .l2_ack_i(l2_ack), .l2_rvalid_i(l2_rvalid), .l2_rdata_i(l2_rdata),
        .state_o(a_state)
    );

    l2_refill_arb #(.B(32)) dut32 (
        .clk_i(clk), .reset_i(reset_i),
        .ic_repl_permit_i(ic_permit), .ic_addr_i(ic_addr),
        .dc_repl_permit_i(dc_permit), .dc_addr_i(dc_addr),
        .ic_repl_ready_o(b_ic_rdy), .dc_repl_ready_o(b_dc_rdy),
        .ic_done_o(b_ic_done), .dc_done_o(b_dc_done),
        .rep_word_o(b_word), .l2_req_o(b_req), .l2_addr_o(b_addr),
        .l2_ack_i(l2_ack), .l2_rvalid_i(l2_rvalid), .l2_rdata_i(l2_rdata),
        .state_o(b_state)
    );

    logic        sel32;
    logic [3:0]  o_flags;
    logic [63:0] o_word;
    logic        o_req;
    logic [31:0] o_addr;
    logic [1:0]  o_state;

    assign o_flags = sel32 ? {b_ic_rdy, b_dc_rdy, b_ic_done, b_dc_done}
                           : {a_ic_rdy, a_dc_rdy, a_ic_done, a_dc_done};
    assign o_word  = sel32 ? b_word : a_word;
    assign o_req   = sel32 ? b_req : a_req;
    assign o_addr  = sel32 ? b_addr : a_addr;
    assign o_state = sel32 ? b_state : a_state;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_flags"}, 64'(o_flags), 64'h0);
        check({tag, "_word"}, o_word, 64'h0);
        check({tag, "_req"}, 64'(o_req), 64'h0);
        check({tag, "_addr"}, 64'(o_addr), 64'h0);
        check({tag, "_state"}, 64'(o_state), 64'(IDLE));
    endtask

    task automatic do_reset();
        reset_i   = 1'b0;
        ic_permit = 1'b0;
        dc_permit = 1'b0;
        l2_ack    = 1'b0;
        l2_rvalid = 1'b0;
        l2_rdata  = '0;
        step();
        step();
        reset_i = 1'b1;
    endtask

    // Called at the first negedge after a grant; returns at the single IDLE cycle.
    task automatic run_fill(input logic is_dc, input logic [31:0] exp_addr, input int ack_wait,
                            input int gap, input logic spur, input int nbeats, input logic [63:0] base);
        check("req_up", 64'(o_req), 64'h1);
        check("req_addr", 64'(o_addr), 64'(exp_addr));
        check("st_req", 64'(o_state), 64'(REQ));
        for (int w = 0; w < ack_wait; w++) begin
            l2_ack    = 1'b0;
            l2_rvalid = spur;
            l2_rdata  = '1;
            step();
            check("stall_req", 64'(o_req), 64'h1);
            check("stall_addr", 64'(o_addr), 64'(exp_addr));
            check("stall_flags", 64'(o_flags), 64'h0);
        end
        l2_rvalid = 1'b0;
        l2_ack    = 1'b1;
        step();
        check("req_drop", 64'(o_req), 64'h0);
        check("st_beat", 64'(o_state), 64'(BEAT));
        l2_ack = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            for (int g = 0; g < gap; g++) begin
                l2_rvalid = 1'b0;
                l2_ack    = spur;
                step();
                check("gap_flags", 64'(o_flags), 64'h0);
            end
            l2_ack    = 1'b0;
            l2_rvalid = 1'b1;
            l2_rdata  = base + 64'(i);
            step();
            check("beat_flags", 64'(o_flags),
                  64'({!is_dc, is_dc, !is_dc && (i == nbeats - 1), is_dc && (i == nbeats - 1)}));
            check("beat_word", o_word, base + 64'(i));
        end
        l2_rvalid = 1'b0;
        check("end_state", 64'(o_state), 64'(IDLE));
        check("end_req", 64'(o_req), 64'h0);
    endtask

    initial begin
        sel32   = 1'b0;
        ic_addr = '0;
        dc_addr = '0;
        do_reset();
        chk_zero("rst");

        // Single icache fill.
        ic_addr   = 32'h0000_1234;
        ic_permit = 1'b1;
        step();
        ic_permit = 1'b0;
        run_fill(1'b0, 32'h0000_1200, 0, 0, 1'b0, 8, 64'hC0DE_0000_0000_0000);

        // Tie from reset: ic, then dc, then ic, each after one IDLE cycle.
        do_reset();
        ic_addr   = 32'h0000_1234;
        dc_addr   = 32'h8000_00FF;
        ic_permit = 1'b1;
        dc_permit = 1'b1;
        step();
        run_fill(1'b0, 32'h0000_1200, 0, 0, 1'b0, 8, 64'h1111_0000_0000_0010);
        step();
        run_fill(1'b1, 32'h8000_00C0, 1, 0, 1'b0, 8, 64'h2222_0000_0000_0020);
        step();
        run_fill(1'b0, 32'h0000_1200, 0, 0, 1'b0, 8, 64'h3333_0000_0000_0030);
        ic_permit = 1'b0;
        dc_permit = 1'b0;
        step();
        check("tie_idle", 64'(o_state), 64'(IDLE));

        // L2 stall: ack held off 5 cycles, rvalid gapped by two idle cycles.
        ic_addr   = 32'h0000_2FC8;
        ic_permit = 1'b1;
        step();
        ic_permit = 1'b0;
        run_fill(1'b0, 32'h0000_2FC0, 5, 2, 1'b0, 8, 64'h4444_0000_0000_0040);

        // Spurious rvalid/ack, permit dropped and address changed mid-fill.
        l2_rvalid = 1'b1;
        l2_ack    = 1'b1;
        step();
        check("idle_spur_flags", 64'(o_flags), 64'h0);
        check("idle_spur_state", 64'(o_state), 64'(IDLE));
        l2_rvalid = 1'b0;
        l2_ack    = 1'b0;
        dc_addr   = 32'h8000_00FF;
        dc_permit = 1'b1;
        step();
        dc_permit = 1'b0;
        dc_addr   = 32'hFFFF_FFFF;
        ic_addr   = 32'h4444_0055;
        ic_permit = 1'b1;
        run_fill(1'b1, 32'h8000_00C0, 2, 1, 1'b1, 8, 64'h5555_0000_0000_0050);
        step();
        ic_permit = 1'b0;
        run_fill(1'b0, 32'h4444_0040, 0, 0, 1'b0, 8, 64'h6666_0000_0000_0060);

        // Reset after the third beat of an icache fill.
        ic_addr   = 32'h0000_1234;
        ic_permit = 1'b1;
        step();
        ic_permit = 1'b0;
        check("mid_req", 64'(o_req), 64'h1);
        l2_ack = 1'b1;
        step();
        l2_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            l2_rvalid = 1'b1;
            l2_rdata  = 64'h7777_0000_0000_0070 + 64'(i);
            step();
            check("mid_flags", 64'(o_flags), 64'b1000);
        end
        l2_rvalid = 1'b0;
        reset_i   = 1'b0;
        #1;
        chk_zero("async_rst");
        dc_addr   = 32'h0000_0ABC;
        dc_permit = 1'b1;
        step();
        check("rst_held_state", 64'(o_state), 64'(IDLE));
        reset_i = 1'b1;
        step();
        dc_permit = 1'b0;
        run_fill(1'b1, 32'h0000_0A80, 0, 0, 1'b0, 8, 64'h8888_0000_0000_0080);

        // B=32 instance: four beats per line.
        sel32 = 1'b1;
        do_reset();
        chk_zero("rst32");
        ic_addr   = 32'h0000_1234;
        ic_permit = 1'b1;
        step();
        ic_permit = 1'b0;
        run_fill(1'b0, 32'h0000_1220, 0, 0, 1'b0, 4, 64'h9999_0000_0000_0090);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_refill_arb.md
# l2_refill_arb

Sequencer and arbiter for the shared L2 refill port. It sits between the L1 instruction cache, the L1 data cache and the L2. It grants one L1 miss at a time using round-robin and issues a line-aligned request to L2. It then counts the returning 64-bit beats and forwards each beat to the granted cache as a registered replacement word with a one-cycle ready pulse.

## Interface
Parameters:
- B, 64, line size in bytes; must be a power of two and ≥ 8.
- BEATS, B/8, derived localparam: 64-bit beats per line.
- BW, $clog2(BEATS) (minimum 1), derived localparam: beat counter width.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- ic_repl_permit_i  in  1  icache miss: refill requested.
- ic_addr_i  in  32  icache miss address (PC).
- dc_repl_permit_i  in  1  dcache miss: refill requested.
- dc_addr_i  in  32  dcache miss address.
- ic_repl_ready_o  out  1  beat valid on rep_word_o for icache (drives icache l2_repl_ready_i).
- dc_repl_ready_o  out  1  beat valid on rep_word_o for dcache.
- ic_done_o / dc_done_o  out  1 each  pulse with the final beat of that requester's line.
- rep_word_o  out  64  registered replacement beat, shared by both caches.
- l2_req_o  out  1  request to L2; held until accepted.
- l2_addr_o  out  32  line-aligned address, low $clog2(B) bits zero.
- l2_ack_i  in  1  L2 accepts the request.
- l2_rvalid_i  in  1  L2 data beat valid.
- l2_rdata_i  in  64  L2 data beat.

## Operation
- States: IDLE, REQ, BEAT.
- **IDLE:**
  - If neither permit is high, stay in IDLE.
  - If one permit is high, grant that cache.
  - If both are high, grant the side not granted last (rr_ptr). After reset, icache wins the first tie.
  - On grant: latch owner, register l2_addr_o = {addr[31:b], b'0}, clear beat_cnt, go to REQ.
- **REQ:**
  - l2_req_o = 1 and l2_addr_o is stable.
  - When l2_ack_i = 1, go to BEAT. The transition is gated by the ack, so l2_req_o deasserts the cycle after the ack.
- **BEAT:**
  - On each l2_rvalid_i: rep_word_o <= l2_rdata_i, owner ready pulses next cycle, beat_cnt++.
  - On beat BEATS-1: the owner's done pulses alongside its ready. Flip rr_ptr to the non-owner and go to IDLE.
- A requester that drops its permit mid-fill is ignored; the line always completes.
- Permit/address changes outside IDLE are ignored; the address is captured at grant only.
- l2_ack_i outside REQ and l2_rvalid_i outside BEAT are ignored (no state change, no ready pulse).
- The non-owner's ready and done outputs stay 0 for the whole fill.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = icache, beat_cnt = 0.
  - All *_ready_o, *_done_o and l2_req_o = 0; l2_addr_o = 0; rep_word_o = 0.
- Reset asserted mid-fill aborts immediately to the reset values. Partial beats already delivered are not retracted.
- Permit high at edge n in IDLE gives l2_req_o = 1 in cycle n+1.
- Ready latency: l2_rvalid_i at edge k gives ready and rep_word_o valid in cycle k+1, for exactly one cycle per beat.
- Back-to-back rvalid produces back-to-back ready pulses.
- After the last beat, the FSM is in IDLE for one cycle; the next grant samples permits in that cycle. Minimum gap between fills is therefore one IDLE cycle.
- beat_cnt never wraps within a fill; it is cleared at grant.

## Structure
- Package l2_refill_pkg:
  - refill_state_t enum {IDLE, REQ, BEAT}.
  - owner_t enum {OWN_IC, OWN_DC}.
  - L2_BEAT_BYTES = 8.
- Sub-module refill_rr_arb2: combinational 2-way round-robin pick from the permits plus rr_ptr, outputting grant_valid and grant_owner. rr_ptr is held in the parent.
- All other logic (FSM, beat counter, output registers) lives in l2_refill_arb.

## Test plan
- **Single icache fill:** ic permit with addr 0x0000_1234 at B=64.
  - l2_addr_o = 0x0000_1200; after ack, 8 rvalid beats 0x..00–0x..07.
  - 8 ic_repl_ready_o pulses carrying matching data; ic_done_o with the 8th; dc outputs stay 0.
- **Tie and round-robin:** both permits high from reset.
  - Icache served first, then dcache, then icache on a third tie.
  - Exactly one IDLE cycle between fills.
- **L2 stall:** l2_ack_i withheld 5 cycles, then rvalid gapped (1,0,0,1,...).
  - l2_req_o and l2_addr_o stable throughout the stall.
  - Ready pulses appear only one cycle after each rvalid; count = 8.
- **Spurious inputs:** rvalid in IDLE/REQ, ack in BEAT, permit dropped mid-fill.
  - No ready pulses from the spurious inputs; the current line completes with 8 beats.
- **Reset mid-fill:** reset_i low after beat 3.
  - All outputs 0 asynchronously.
  - After release, a dcache permit is granted immediately; rr_ptr is back at the icache default.
- **Parameter B=32:** 4 beats per line; done asserted with the 4th beat.
